// File: rtl/rr_budget_pkg.sv
// Shared types and helpers for the round-robin budget arbiter.
// Helpers work on a fixed 32-bit request vector so they can serve any NUM_REQ up to 32.
package rr_budget_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int MAX_REQ = 32;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  function automatic req_vec_t onehot(input int idx);
    onehot = req_vec_t'(1) << idx;
  endfunction

  // Scans from the highest offset down so the requester closest to ptr wins.
  function automatic int rr_pick(input req_vec_t req, input int ptr, input int num);
    req_vec_t shifted;
    int       cand;
    rr_pick = ptr;
    for (int off = MAX_REQ - 1; off >= 0; off--) begin
      if (off < num) begin
        cand    = (ptr + off) % num;
        shifted = req >> cand;
        if (shifted[0]) begin
          rr_pick = cand;
        end
      end
    end
  endfunction

endpackage

// File: rtl/VX_common_cells_counter.sv
// Loadable up/down counter with clear, and a wrap indication that is either
// a per-cycle pulse or a sticky flag.
module VX_common_cells_counter #(
  parameter int WIDTH           = 4,
  parameter bit STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Clear beats load, load beats counting; only a real count step can wrap.
  assign wrap = en_i && !clear_i && !load_i &&
                (down_i ? (cnt_q == '0) : (cnt_q == '1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = d_i;
    end else if (en_i) begin
      cnt_d = down_i ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

  generate
    if (STICKY_OVERFLOW) begin : g_sticky
      logic ovf_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ovf_q <= 1'b0;
        end else if (clear_i || load_i) begin
          ovf_q <= 1'b0;
        end else if (wrap) begin
          ovf_q <= 1'b1;
        end
      end
      assign overflow_o = ovf_q;
    end else begin : g_pulse
      assign overflow_o = wrap;
    end
  endgenerate

endmodule

// File: rtl/rr_budget_arbiter.sv
// Round-robin arbiter where each grant carries a beat budget tracked by one
// shared down-counter; a grant ends on request drop, budget exhaustion or flush.
module rr_budget_arbiter
  import rr_budget_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BUDGET_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [BUDGET_W-1:0] budget_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                beat_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                busy_o,
  output logic [BUDGET_W-1:0] remaining_o,
  output logic                expired_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                expired_q, expired_d;
  logic                zero_q, zero_d;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [BUDGET_W-1:0] cnt_q;
  logic                cnt_wrap;
  logic                load_cnt;
  logic                beat_en;
  logic                exhaust;
  logic                rel_grant;
  logic                underflow;

  assign pick_idx  = IDX_W'(rr_pick(req_vec_t'(req_i), int'(ptr_q), NUM_REQ));
  assign next_ptr  = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign load_cnt  = (state_q == IDLE) && (|req_i) && !flush_i;
  assign beat_en   = beat_i && (state_q == GRANT);
  assign exhaust   = beat_en && (cnt_q == BUDGET_W'(1));
  assign rel_grant = (state_q == GRANT) && !req_i[gnt_idx_q];
  // A zero budget wraps 0 -> all-ones on its first beat; only later wraps are errors.
  assign underflow = cnt_wrap && !zero_q;

  VX_common_cells_counter #(
    .WIDTH          (BUDGET_W),
    .STICKY_OVERFLOW(1'b0)
  ) u_beat_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (flush_i),
    .en_i      (beat_en),
    .load_i    (load_cnt),
    .down_i    (1'b1),
    .d_i       (budget_i),
    .q_o       (cnt_q),
    .overflow_o(cnt_wrap)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      expired_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      expired_q <= expired_d;
      zero_q    <= zero_d;
    end
  end

  // Flush wins in every state and leaves the pointer where it was.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    expired_d = 1'b0;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          zero_d = 1'b0;
        end else if (|req_i) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
          zero_d    = (budget_i == '0);
        end
      end
      GRANT: begin
        if (flush_i) begin
          state_d = IDLE;
          zero_d  = 1'b0;
        end else begin
          if (beat_i) begin
            zero_d = 1'b0;
          end
          if (underflow || exhaust || rel_grant) begin
            state_d   = IDLE;
            ptr_d     = next_ptr;
            expired_d = exhaust;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_o       = '0;
    busy_o      = 1'b0;
    remaining_o = '0;
    if (state_q == GRANT) begin
      gnt_o       = NUM_REQ'(onehot(int'(gnt_idx_q)));
      busy_o      = 1'b1;
      remaining_o = cnt_q;
    end
  end

  assign gnt_idx_o = gnt_idx_q;
  assign expired_o = expired_q;

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow);

endmodule

// File: tb/tb_rr_budget_arbiter.sv
// Directed bench for rr_budget_arbiter: budget exhaustion, rotation, release,
// zero budget, flush and asynchronous reset, all against hand-computed values.
module tb_rr_budget_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int BUDGET_W = 4;
  localparam int IDX_W    = 2;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                flush = 1'b0;
  logic [BUDGET_W-1:0] budget = '0;
  logic [NUM_REQ-1:0]  req = '0;
  logic                beat = 1'b0;
  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gntIdx;
  logic                busy;
  logic [BUDGET_W-1:0] remaining;
  logic                expired;

  int checkCount = 0;
  int passCount  = 0;

  rr_budget_arbiter #(
    .NUM_REQ (NUM_REQ),
    .BUDGET_W(BUDGET_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .flush_i    (flush),
    .budget_i   (budget),
    .req_i      (req),
    .beat_i     (beat),
    .gnt_o      (gnt),
    .gnt_idx_o  (gntIdx),
    .busy_o     (busy),
    .remaining_o(remaining),
    .expired_o  (expired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at a falling edge, let one rising edge act, return at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic b, input logic [3:0] bud, input logic f);
    req    = r;
    beat   = b;
    budget = bud;
    flush  = f;
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN   = 1'b0;
    req    = '0;
    beat   = 1'b0;
    budget = '0;
    flush  = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // single requester, budget 3, beat held high
    doReset();
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_idx", 32'(gntIdx), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rem", 32'(remaining), 32'h0);
    checkOutput("rst_exp", 32'(expired), 32'h0);
    applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0);
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_rem3", 32'(remaining), 32'd3);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0);
    checkOutput("t1_rem2", 32'(remaining), 32'd2);
    applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0);
    checkOutput("t1_rem1", 32'(remaining), 32'd1);
    checkOutput("t1_noexp", 32'(expired), 32'h0);
    applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0);
    checkOutput("t1_exp", 32'(expired), 32'h1);
    checkOutput("t1_bubble", 32'(gnt), 32'h0);
    checkOutput("t1_idlebusy", 32'(busy), 32'h0);
    applyStimulus(4'b0001, 1'b1, 4'd3, 1'b0);
    checkOutput("t1_regnt", 32'(gnt), 32'h1);
    checkOutput("t1_rerem", 32'(remaining), 32'd3);
    checkOutput("t1_expend", 32'(expired), 32'h0);

    // all four requesting, budget 2: rotation 0,1,2,3,0
    doReset();
    for (int g = 0; g < 5; g++) begin
      applyStimulus(4'b1111, 1'b1, 4'd2, 1'b0);
      checkOutput("rot_idx", 32'(gntIdx), 32'(g % 4));
      checkOutput("rot_gnt", 32'(gnt), 32'h1 << (g % 4));
      checkOutput("rot_rem2", 32'(remaining), 32'd2);
      applyStimulus(4'b1111, 1'b1, 4'd2, 1'b0);
      checkOutput("rot_rem1", 32'(remaining), 32'd1);
      applyStimulus(4'b1111, 1'b1, 4'd2, 1'b0);
      checkOutput("rot_exp", 32'(expired), 32'h1);
      checkOutput("rot_bubble", 32'(busy), 32'h0);
    end

    // voluntary release by index 1 after two beats
    doReset();
    applyStimulus(4'b0110, 1'b0, 4'd5, 1'b0);
    checkOutput("rel_idx", 32'(gntIdx), 32'd1);
    checkOutput("rel_rem5", 32'(remaining), 32'd5);
    applyStimulus(4'b0110, 1'b1, 4'd5, 1'b0);
    applyStimulus(4'b0110, 1'b1, 4'd5, 1'b0);
    checkOutput("rel_rem3", 32'(remaining), 32'd3);
    applyStimulus(4'b0100, 1'b0, 4'd5, 1'b0);
    checkOutput("rel_busy", 32'(busy), 32'h0);
    checkOutput("rel_noexp", 32'(expired), 32'h0);
    checkOutput("rel_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'b0110, 1'b0, 4'd5, 1'b0);
    checkOutput("rel_next_idx", 32'(gntIdx), 32'd2);
    checkOutput("rel_next_gnt", 32'(gnt), 32'h4);
    checkOutput("rel_next_rem", 32'(remaining), 32'd5);

    // flush mid-grant on index 2 (pointer is 2 here)
    applyStimulus(4'b0110, 1'b1, 4'd5, 1'b0);
    applyStimulus(4'b0110, 1'b1, 4'd5, 1'b0);
    checkOutput("fl_rem3", 32'(remaining), 32'd3);
    applyStimulus(4'b1111, 1'b1, 4'd5, 1'b1);
    checkOutput("fl_gnt", 32'(gnt), 32'h0);
    checkOutput("fl_rem", 32'(remaining), 32'h0);
    checkOutput("fl_noexp", 32'(expired), 32'h0);
    checkOutput("fl_busy", 32'(busy), 32'h0);
    applyStimulus(4'b1111, 1'b0, 4'd5, 1'b0);
    checkOutput("fl_regnt_idx", 32'(gntIdx), 32'd2);
    checkOutput("fl_regnt_gnt", 32'(gnt), 32'h4);

    // zero budget means 16 beats
    doReset();
    applyStimulus(4'b0001, 1'b1, 4'd0, 1'b0);
    checkOutput("z_busy", 32'(busy), 32'h1);
    checkOutput("z_rem0", 32'(remaining), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(4'b0001, 1'b1, 4'd0, 1'b0);
      checkOutput("z_rem", 32'(remaining), 32'(16 - k));
      checkOutput("z_hold", 32'(busy), 32'h1);
    end
    applyStimulus(4'b0001, 1'b1, 4'd0, 1'b0);
    checkOutput("z_exp", 32'(expired), 32'h1);
    checkOutput("z_done", 32'(busy), 32'h0);

    // asynchronous reset while index 3 holds the grant
    doReset();
    applyStimulus(4'b1000, 1'b0, 4'd4, 1'b0);
    checkOutput("ar_gnt", 32'(gnt), 32'h8);
    req = 4'b1111;
    #2 rstN = 1'b0;
    #1;
    checkOutput("ar_gnt0", 32'(gnt), 32'h0);
    checkOutput("ar_busy0", 32'(busy), 32'h0);
    checkOutput("ar_rem0", 32'(remaining), 32'h0);
    checkOutput("ar_idx0", 32'(gntIdx), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(4'b1111, 1'b0, 4'd4, 1'b0);
    checkOutput("ar_first_idx", 32'(gntIdx), 32'd0);
    checkOutput("ar_first_gnt", 32'(gnt), 32'h1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rr_budget_arbiter.md
Name: rr_budget_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Each grant carries a beat budget. The winner holds the grant until it drops its request or spends the budget, whichever comes first.
- The budget is tracked by one shared down-counter, so a single requester cannot monopolise the resource.
- Sits in front of shared ports such as an FPU lane or a memory port.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
BUDGET_W, 4, width of the beat budget and remaining-beat counter
IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort: drop the grant, return to IDLE, keep the RR pointer
budget_i  in  BUDGET_W  beats per grant, sampled when a grant is issued; 0 means 2^BUDGET_W
req_i  in  NUM_REQ  per-requester request, level-sensitive
beat_i  in  1  granted requester completed one transfer this cycle
gnt_o  out  NUM_REQ  one-hot grant, registered
gnt_idx_o  out  IDX_W  index of the current grant holder
busy_o  out  1  a grant is active
remaining_o  out  BUDGET_W  beats left in the current grant
expired_o  out  1  one-cycle pulse when a grant ends by budget exhaustion

Behaviour:
- Reset values: state=IDLE, gnt_o=0, gnt_idx_o=0, busy_o=0, remaining_o=0, expired_o=0, RR pointer=0.
- State IDLE:
  - Combinational RR pick: first asserted req_i at or after the pointer, modulo NUM_REQ.
  - If any req_i is set: register the winner, load the counter with budget_i, go to GRANT.
  - gnt_o asserts the next cycle, so grant latency is 1 cycle from request.
- State GRANT:
  - gnt_o=onehot(gnt_idx_o), busy_o=1.
  - beat_i decrements the counter; beat_i is ignored outside GRANT.
- Budget exhaustion: beat_i=1 while remaining_o==1 → next cycle IDLE, expired_o=1 for one cycle, pointer=winner+1 (wraps NUM_REQ-1 → 0).
- Voluntary release: req_i[winner]=0 and beat_i=0 → next cycle IDLE, pointer=winner+1, no expired_o pulse.
- Last beat with request drop: req_i[winner]=0 and beat_i=1 in the same cycle count the beat. If remaining_o==1 it is an exhaustion (expired_o pulses); otherwise it is a release.
- No back-to-back grants: after every release there is one IDLE cycle (gnt_o=0) before the next grant. This bubble is intentional.
- budget_i==0: the counter loads 0 and the 2^BUDGET_W-th beat (0→wrap) is treated as exhaustion. Implement with a "loaded zero" flag so remaining_o reads 0 until the first beat.
- flush_i: highest priority in any state.
  - Next cycle: IDLE, gnt_o=0, counter cleared, expired_o=0.
  - Pointer unchanged.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous).
- Fairness: with all NUM_REQ requesters asserted continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Counter arithmetic: BUDGET_W bits, down-count only, no underflow in normal operation. If underflow is reached, an assertion fires and the state goes to IDLE.

Decomposition:
- Shared package rr_budget_pkg:
  - state enum {IDLE, GRANT}, 1 bit.
  - Helper function onehot(idx) and the RR-pick function (priority mask from pointer).
- One sub-module instance: VX_common_cells_counter for the remaining-beat count, connected as follows:
  - WIDTH=BUDGET_W, STICKY_OVERFLOW=0.
  - down_i=1, load_i on grant issue, en_i=beat_i&&GRANT, clear_i=flush_i.
- The arbiter FSM and pointer logic stay in the top module.

Test Plan:
- Single requester: req_i=0001, budget_i=3, beat_i held 1 → gnt_o=0001 from cycle 1. remaining_o goes 3,2,1. expired_o pulses on cycle 4, then IDLE bubble, then regrant 0001 with remaining_o=3.
- Fair rotation: req_i=1111, budget_i=2, beat_i=1 → gnt_idx_o sequence 0,1,2,3,0, each grant lasting 2 cycles with 1 IDLE cycle between grants. expired_o pulses 5 times.
- Voluntary release: req_i=0110, budget_i=5, two beats, then req_i[1]=0 with beat_i=0 → busy_o drops next cycle, remaining_o was 3, no expired_o. Next grant goes to index 2.
- Zero budget: budget_i=0, BUDGET_W=4, beat_i=1 continuously → grant lasts exactly 16 beats, expired_o on the 17th cycle.
- Flush mid-grant: grant to index 2 with remaining_o=3, assert flush_i → next cycle gnt_o=0, remaining_o=0, no expired_o. With req_i=1111 the next grant goes to index 2 again because the pointer is unchanged.
- Async reset mid-grant: pull rst_ni low between clock edges while gnt_o=1000 → gnt_o, busy_o and remaining_o read 0 before the next edge. After release, the first grant goes to index 0.
